// File: rtl/tshoot_gun_pkg.sv
// Shared types and constants for the gun crosshair controller.
package tshoot_gun_pkg;

  // Per-axis acceleration state.
  typedef enum logic [1:0] {
    AX_IDLE = 2'd0,
    AX_SLOW = 2'd1,
    AX_FAST = 2'd2
  } axis_state_t;

  // Default internal position width and its centre value.
  localparam int unsigned              GUN_POS_W      = 10;
  localparam logic [GUN_POS_W-1:0]     GUN_POS_CENTRE = 10'd512;

  // Raw mouse delta width from the hps_io decode.
  localparam int unsigned              MOUSE_W        = 9;

  // True when exactly one of two opposing directions is held.
  function automatic logic single_dir(input logic a, input logic b);
    return a ^ b;
  endfunction

endpackage : tshoot_gun_pkg

// File: rtl/tshoot_gun_axis.sv
// One crosshair axis: slow/fast acceleration FSM, hold counter and a
// saturating fixed-point position register fed by joystick and mouse.
module tshoot_gun_axis
  import tshoot_gun_pkg::*;
#(
  parameter int unsigned POS_W       = 10,
  parameter int unsigned STEP_SLOW   = 4,
  parameter int unsigned STEP_FAST   = 12,
  parameter int unsigned ACCEL_TICKS = 32,
  parameter int unsigned MOUSE_SHIFT = 2,
  parameter int unsigned D_W         = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_dir_pos,
  input  logic                  i_dir_neg,
  input  logic                  i_tick_ev,
  input  logic                  i_d_stb,
  input  logic signed [D_W-1:0] i_d_val,
  input  logic                  i_recentre,
  output logic [POS_W-1:0]      o_pos
);

  // Three guard bits cover the largest mouse jump plus a joystick step.
  localparam int unsigned SUM_W = POS_W + 3;
  localparam int unsigned CNT_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [POS_W-1:0]        CENTRE   = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [POS_W-1:0]        POS_MAX  = {POS_W{1'b1}};
  localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(ACCEL_TICKS - 1);
  localparam logic signed [SUM_W-1:0] SLOW_S   = SUM_W'(STEP_SLOW);
  localparam logic signed [SUM_W-1:0] FAST_S   = SUM_W'(STEP_FAST);
  localparam logic signed [SUM_W-1:0] SUM_MAX  = SUM_W'(POS_MAX);
  localparam logic signed [SUM_W-1:0] SUM_ZERO = {SUM_W{1'b0}};

  axis_state_t       r_state;
  axis_state_t       w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              r_dir_neg;
  logic              w_dir_nx;
  logic [POS_W-1:0]  r_pos;
  logic [POS_W-1:0]  w_pos_nx;

  logic                    w_single;
  logic                    w_reversal;
  logic signed [SUM_W-1:0] w_step_mag;
  logic signed [SUM_W-1:0] w_step;
  logic signed [SUM_W-1:0] w_d_ext;
  logic signed [SUM_W-1:0] w_mouse;
  logic signed [SUM_W-1:0] w_pos_ext;
  logic signed [SUM_W-1:0] w_sum;

  assign w_single   = single_dir(i_dir_pos, i_dir_neg);
  assign w_reversal = (i_dir_neg != r_dir_neg);
  assign w_d_ext    = SUM_W'(i_d_val);
  assign w_pos_ext  = signed'({3'b000, r_pos});

  // Acceleration FSM: decides next state, counter, direction and step size.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_dir_nx   = r_dir_neg;
    w_step_mag = SUM_ZERO;
    if (i_recentre) begin
      w_state_nx = AX_IDLE;
      w_cnt_nx   = CNT_ZERO;
    end else if (i_tick_ev) begin
      if (!w_single) begin
        w_state_nx = AX_IDLE;
        w_cnt_nx   = CNT_ZERO;
      end else begin
        w_dir_nx = i_dir_neg;
        case (r_state)
          AX_IDLE: begin
            // The entry tick already counts as one held tick.
            w_state_nx = AX_SLOW;
            w_cnt_nx   = CNT_ONE;
            w_step_mag = SLOW_S;
          end
          AX_SLOW: begin
            w_step_mag = SLOW_S;
            if (w_reversal) begin
              w_cnt_nx = CNT_ZERO;
            end else if (r_cnt == CNT_LAST) begin
              w_state_nx = AX_FAST;
            end else begin
              w_cnt_nx = r_cnt + CNT_ONE;
            end
          end
          AX_FAST: begin
            if (w_reversal) begin
              w_state_nx = AX_SLOW;
              w_cnt_nx   = CNT_ZERO;
              w_step_mag = SLOW_S;
            end else begin
              w_step_mag = FAST_S;
            end
          end
          default: begin
            w_state_nx = AX_IDLE;
            w_cnt_nx   = CNT_ZERO;
          end
        endcase
      end
    end else begin
      w_state_nx = r_state;
    end
  end

  // Signed sum of position, joystick step and scaled mouse delta, then clamp.
  always_comb begin
    w_step   = i_dir_neg ? -w_step_mag : w_step_mag;
    w_mouse  = SUM_ZERO;
    w_sum    = SUM_ZERO;
    w_pos_nx = r_pos;
    if (i_d_stb) begin
      w_mouse = w_d_ext <<< MOUSE_SHIFT;
    end else begin
      w_mouse = SUM_ZERO;
    end
    w_sum = w_pos_ext + w_step + w_mouse;
    if (i_recentre) begin
      w_pos_nx = CENTRE;
    end else if (w_sum[SUM_W-1]) begin
      w_pos_nx = {POS_W{1'b0}};
    end else if (w_sum > SUM_MAX) begin
      w_pos_nx = POS_MAX;
    end else begin
      w_pos_nx = w_sum[POS_W-1:0];
    end
  end

  // State, hold counter, held direction and position registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= AX_IDLE;
      r_cnt     <= CNT_ZERO;
      r_dir_neg <= 1'b0;
      r_pos     <= CENTRE;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_dir_neg <= w_dir_nx;
      r_pos     <= w_pos_nx;
    end
  end

  assign o_pos = r_pos;

endmodule : tshoot_gun_axis

// File: rtl/tshoot_gun_ctrl.sv
// Joystick/mouse to absolute gun crosshair converter for the williams2 core.
// Paced by the core's 4 ms tick; one axis instance per direction.
module tshoot_gun_ctrl
  import tshoot_gun_pkg::*;
#(
  parameter int unsigned OUT_W       = 6,
  parameter int unsigned POS_W       = GUN_POS_W,
  parameter int unsigned STEP_SLOW   = 4,
  parameter int unsigned STEP_FAST   = 12,
  parameter int unsigned ACCEL_TICKS = 32,
  parameter int unsigned MOUSE_SHIFT = 2,
  parameter int unsigned INV_V       = 0
) (
  input  logic                      i_clock_12,
  input  logic                      i_reset,
  input  logic                      i_tick_4ms,
  input  logic                      i_joy_right,
  input  logic                      i_joy_left,
  input  logic                      i_joy_down,
  input  logic                      i_joy_up,
  input  logic                      i_recentre,
  input  logic                      i_mouse_stb,
  input  logic signed [MOUSE_W-1:0] i_mouse_dx,
  input  logic signed [MOUSE_W-1:0] i_mouse_dy,
  output logic [OUT_W-1:0]          o_gun_h,
  output logic [OUT_W-1:0]          o_gun_v
);

  // One extra bit so that negating the most negative delta cannot overflow.
  localparam int unsigned D_W = MOUSE_W + 1;

  logic                  r_tick_d;
  logic                  w_tick_ev;
  logic signed [D_W-1:0] w_dx_ext;
  logic signed [D_W-1:0] w_dy_ext;
  logic signed [D_W-1:0] w_dy_adj;
  logic                  w_v_pos;
  logic                  w_v_neg;
  logic [POS_W-1:0]      w_pos_h;
  logic [POS_W-1:0]      w_pos_v;
  logic                  w_unused_lsbs;

  // Rising-edge detector on the core tick (already in the clock_12 domain).
  always_ff @(posedge i_clock_12 or posedge i_reset) begin
    if (i_reset) begin
      r_tick_d <= 1'b0;
    end else begin
      r_tick_d <= i_tick_4ms;
    end
  end

  assign w_tick_ev = i_tick_4ms & ~r_tick_d;

  assign w_dx_ext = {i_mouse_dx[MOUSE_W-1], i_mouse_dx};
  assign w_dy_ext = {i_mouse_dy[MOUSE_W-1], i_mouse_dy};

  // Vertical inversion swaps the stick sense and negates the mouse term.
  assign w_dy_adj = (INV_V != 0) ? -w_dy_ext : w_dy_ext;
  assign w_v_pos  = (INV_V != 0) ? i_joy_up   : i_joy_down;
  assign w_v_neg  = (INV_V != 0) ? i_joy_down : i_joy_up;

  tshoot_gun_axis #(
    .POS_W       (POS_W),
    .STEP_SLOW   (STEP_SLOW),
    .STEP_FAST   (STEP_FAST),
    .ACCEL_TICKS (ACCEL_TICKS),
    .MOUSE_SHIFT (MOUSE_SHIFT),
    .D_W         (D_W)
  ) u_axis_h (
    .i_clk      (i_clock_12),
    .i_rst      (i_reset),
    .i_dir_pos  (i_joy_right),
    .i_dir_neg  (i_joy_left),
    .i_tick_ev  (w_tick_ev),
    .i_d_stb    (i_mouse_stb),
    .i_d_val    (w_dx_ext),
    .i_recentre (i_recentre),
    .o_pos      (w_pos_h)
  );

  tshoot_gun_axis #(
    .POS_W       (POS_W),
    .STEP_SLOW   (STEP_SLOW),
    .STEP_FAST   (STEP_FAST),
    .ACCEL_TICKS (ACCEL_TICKS),
    .MOUSE_SHIFT (MOUSE_SHIFT),
    .D_W         (D_W)
  ) u_axis_v (
    .i_clk      (i_clock_12),
    .i_rst      (i_reset),
    .i_dir_pos  (w_v_pos),
    .i_dir_neg  (w_v_neg),
    .i_tick_ev  (w_tick_ev),
    .i_d_stb    (i_mouse_stb),
    .i_d_val    (w_dy_adj),
    .i_recentre (i_recentre),
    .o_pos      (w_pos_v)
  );

  // The core only sees the top OUT_W bits; the fraction bits stay internal.
  assign o_gun_h = w_pos_h[POS_W-1 -: OUT_W];
  assign o_gun_v = w_pos_v[POS_W-1 -: OUT_W];

  assign w_unused_lsbs = ^{w_pos_h[POS_W-OUT_W-1:0], w_pos_v[POS_W-OUT_W-1:0]};

endmodule : tshoot_gun_ctrl

// File: tb/tb_tshoot_gun_ctrl.sv
// Self-checking bench for tshoot_gun_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural position model.
module tb_tshoot_gun_ctrl;
  import tshoot_gun_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick, jr, jl, jd, ju, rc, stb;
  logic signed [8:0] dx, dy;
  logic [5:0]        gh0, gv0, gh1, gv1;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state, indexed [instance][axis]; instance 1 has INV_V=1.
  int mpos  [2][2];
  bit mact  [2][2];
  bit mfast [2][2];
  int mdir  [2][2];
  int mcnt  [2][2];
  bit mtick_d;

  always #5 clk = ~clk;

  tshoot_gun_ctrl #(.INV_V(0)) u_dut0 (
    .i_clock_12(clk), .i_reset(rst), .i_tick_4ms(tick),
    .i_joy_right(jr), .i_joy_left(jl), .i_joy_down(jd), .i_joy_up(ju),
    .i_recentre(rc), .i_mouse_stb(stb), .i_mouse_dx(dx), .i_mouse_dy(dy),
    .o_gun_h(gh0), .o_gun_v(gv0)
  );

  tshoot_gun_ctrl #(.INV_V(1)) u_dut1 (
    .i_clock_12(clk), .i_reset(rst), .i_tick_4ms(tick),
    .i_joy_right(jr), .i_joy_left(jl), .i_joy_down(jd), .i_joy_up(ju),
    .i_recentre(rc), .i_mouse_stb(stb), .i_mouse_dx(dx), .i_mouse_dy(dy),
    .o_gun_h(gh1), .o_gun_v(gv1)
  );

  typedef struct {
    int tk; int r; int l; int d; int u; int rc; int stb;
    int dx; int dy; int eh; int ev;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 2; a++) begin
        mpos[i][a] = 512; mact[i][a] = 1'b0; mfast[i][a] = 1'b0;
        mdir[i][a] = 0;   mcnt[i][a] = 0;
      end
    end
    mtick_d = 1'b0;
  endtask

  // Applies the movement rules to the inputs seen at the clock edge just taken.
  task automatic model_step();
    bit tev;
    int p, n, d, js, sum, dir;
    tev     = tick && !mtick_d;
    mtick_d = tick;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 2; a++) begin
        if (a == 0) begin
          p = int'(jr); n = int'(jl); d = int'(dx);
        end else if (i == 0) begin
          p = int'(jd); n = int'(ju); d = int'(dy);
        end else begin
          p = int'(ju); n = int'(jd); d = -int'(dy);
        end
        if (rc) begin
          mpos[i][a] = 512; mact[i][a] = 1'b0; mfast[i][a] = 1'b0; mcnt[i][a] = 0;
        end else begin
          js = 0;
          if (tev) begin
            if (p == n) begin
              mact[i][a] = 1'b0; mfast[i][a] = 1'b0; mcnt[i][a] = 0;
            end else begin
              dir = (p != 0) ? 1 : -1;
              if (!mact[i][a]) begin
                mact[i][a] = 1'b1; mfast[i][a] = 1'b0; mcnt[i][a] = 1; js = 4 * dir;
              end else if (dir != mdir[i][a]) begin
                mfast[i][a] = 1'b0; mcnt[i][a] = 0; js = 4 * dir;
              end else if (mfast[i][a]) begin
                js = 12 * dir;
              end else begin
                js = 4 * dir;
                if (mcnt[i][a] == 31) mfast[i][a] = 1'b1;
                else mcnt[i][a]++;
              end
              mdir[i][a] = dir;
            end
          end
          sum = mpos[i][a] + js + (stb ? d * 4 : 0);
          if (sum < 0) sum = 0;
          if (sum > 1023) sum = 1023;
          mpos[i][a] = sum;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("gun_h0", gh0, mpos[0][0] >> 4);
    check("gun_v0", gv0, mpos[0][1] >> 4);
    check("gun_h1", gh1, mpos[1][0] >> 4);
    check("gun_v1", gv1, mpos[1][1] >> 4);
    check("pos_h0", u_dut0.u_axis_h.r_pos, mpos[0][0]);
    check("pos_v0", u_dut0.u_axis_v.r_pos, mpos[0][1]);
  endtask

  // One clock: inputs already driven; sample #1 after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic do_tick(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask

  task automatic recentre_pulse();
    rc = 1'b1; cyc(); rc = 1'b0;
  endtask

  initial begin
    // tk r l d u rc stb dx dy eh ev
    tbl[0] = '{0, 0, 0, 0, 0, 0, 1,   16,   0, 36, 32};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 1,    0, -32, 36, 24};
    tbl[2] = '{1, 1, 0, 0, 0, 0, 0,    0,   0, 36, 24};
    tbl[3] = '{0, 1, 0, 0, 0, 0, 0,    0,   0, 36, 24};
    tbl[4] = '{1, 0, 0, 0, 1, 0, 0,    0,   0, 36, 23};
    tbl[5] = '{0, 0, 0, 0, 0, 1, 0,    0,   0, 32, 32};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 1,   -1,   1, 31, 32};
    tbl[7] = '{1, 1, 0, 0, 0, 1, 1,  100,   0, 32, 32};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 1, -256, 255,  0, 63};
    tbl[9] = '{1, 0, 1, 0, 0, 0, 1,    3,   0,  0, 63};

    rst = 1'b1; tick = 1'b0; jr = 1'b0; jl = 1'b0; jd = 1'b0; ju = 1'b0;
    rc = 1'b0; stb = 1'b0; dx = 9'sd0; dy = 9'sd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_gun_h", gh0, 32);
    check("reset_gun_v", gv0, 32);
    rst = 1'b0;

    // Idle ticks: nothing moves.
    do_tick(100);
    check("idle_pos_h", u_dut0.u_axis_h.r_pos, 512);
    check("idle_pos_v", u_dut0.u_axis_v.r_pos, 512);

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      tick = (tbl[i].tk != 0); jr = (tbl[i].r != 0); jl = (tbl[i].l != 0);
      jd = (tbl[i].d != 0); ju = (tbl[i].u != 0); rc = (tbl[i].rc != 0);
      stb = (tbl[i].stb != 0); dx = 9'(tbl[i].dx); dy = 9'(tbl[i].dy);
      cyc();
      check($sformatf("vec%0d_gun_h", i), gh0, tbl[i].eh);
      check($sformatf("vec%0d_gun_v", i), gv0, tbl[i].ev);
    end
    tick = 1'b0; jr = 1'b0; jl = 1'b0; jd = 1'b0; ju = 1'b0; rc = 1'b0;
    stb = 1'b0; dx = 9'sd0; dy = 9'sd0;
    cyc();

    // Hold right: 32 slow ticks then fast.
    recentre_pulse();
    jr = 1'b1;
    do_tick(31);
    check("accel_slow31", u_dut0.u_axis_h.r_state, AX_SLOW);
    do_tick(1);
    check("accel_fast32", u_dut0.u_axis_h.r_state, AX_FAST);
    do_tick(8);
    check("accel_pos_h", u_dut0.u_axis_h.r_pos, 736);
    check("accel_gun_h", gh0, 46);

    // Recentre during fast motion.
    recentre_pulse();
    check("rc_pos_h", u_dut0.u_axis_h.r_pos, 512);
    check("rc_state", u_dut0.u_axis_h.r_state, AX_IDLE);
    jr = 1'b0;

    // Long left hold saturates at zero without wrapping.
    jl = 1'b1;
    do_tick(500);
    check("sat_lo_pos", u_dut0.u_axis_h.r_pos, 0);
    check("sat_lo_gun", gh0, 0);
    jl = 1'b0;
    do_tick(1);
    check("release_idle", u_dut0.u_axis_h.r_state, AX_IDLE);
    check("release_pos", u_dut0.u_axis_h.r_pos, 0);

    // Opposing vertical directions cancel; inverted instance runs the other way.
    recentre_pulse();
    ju = 1'b1; jd = 1'b1;
    do_tick(10);
    check("updown_gun_v0", gv0, 32);
    check("updown_gun_v1", gv1, 32);
    check("updown_idle", u_dut0.u_axis_v.r_state, AX_IDLE);
    ju = 1'b0;
    do_tick(5);
    check("down_gun_v0", gv0, 33);
    check("down_inv_gun_v1", gv1, 30);
    jd = 1'b0;

    // Mouse saturation at the top, then combined tick + mouse update.
    recentre_pulse();
    stb = 1'b1; dx = 9'sd255;
    cyc(); cyc(); cyc();
    stb = 1'b0; dx = 9'sd0;
    check("sat_hi_pos", u_dut0.u_axis_h.r_pos, 1023);
    check("sat_hi_gun", gh0, 63);
    jr = 1'b1;
    do_tick(1);
    tick = 1'b1; stb = 1'b1; dx = -9'sd256;
    cyc();
    tick = 1'b0; stb = 1'b0; dx = 9'sd0;
    check("combo_pos_h", u_dut0.u_axis_h.r_pos, 3);
    jr = 1'b0;
    cyc();

    // Asynchronous reset between clock edges.
    recentre_pulse();
    stb = 1'b1; dx = 9'sd50; cyc(); stb = 1'b0; dx = 9'sd0;
    #2;
    tick = 1'b1; rst = 1'b1;
    #1;
    check("async_gun_h0", gh0, 32);
    check("async_gun_v0", gv0, 32);
    check("async_gun_h1", gh1, 32);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    tick = 1'b0; rst = 1'b0;
    cyc();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(255) == 0) begin
        {jr, jl, jd, ju} = 4'($urandom_range(15));
      end
      tick = 1'($urandom_range(1));
      stb  = ($urandom_range(7) == 0);
      dx   = 9'($urandom_range(511));
      dy   = 9'($urandom_range(511));
      rc   = ($urandom_range(127) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tshoot_gun_ctrl
